// File: rtl/forward_ctrl_pkg.sv
// forward_ctrl_pkg: shared types and constants for the EX-stage forwarding controller.
//   stage_ctrl_t : per-stage shadow record of destination/source register metadata.
//   FWD_*        : select codes driven into the EX operand mux4input instances.
package forward_ctrl_pkg;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wren;
      logic       load;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rs1_use;
      logic       rs2_use;
   } stage_ctrl_t;

   // Must track `DATA_00..`DATA_11 as decoded by mux4input.
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;
   localparam logic [1:0] FWD_RET = 2'b11;

   localparam stage_ctrl_t STAGE_BUBBLE = '0;

   // x0 is hardwired, so a write to it never produces a forwardable value.
   function automatic logic is_writer(stage_ctrl_t s);
      return s.valid & s.wren & (s.rd != 5'd0);
   endfunction

endpackage

// File: rtl/fwd_sel_cmp.sv
// fwd_sel_cmp: priority comparator producing one EX operand mux select.
//   rs_i     : source register address of the EX instruction
//   rs_use_i : operand is read by a valid EX instruction
//   mem_i    : shadow record of the MEM stage (youngest, highest priority)
//   wb_i     : shadow record of the WB stage
//   ret_i    : shadow record of the retired stage
//   sel_o    : FWD_MEM / FWD_WB / FWD_RET on a match, FWD_RF otherwise
module fwd_sel_cmp
   import forward_ctrl_pkg::*;
(
   input  logic [4:0]  rs_i,
   input  logic        rs_use_i,
   input  stage_ctrl_t mem_i,
   input  stage_ctrl_t wb_i,
   input  stage_ctrl_t ret_i,
   output logic [1:0]  sel_o
);

   always_comb begin
      sel_o = FWD_RF;
      if (rs_use_i && (rs_i != 5'd0)) begin
         if (is_writer(mem_i) && (mem_i.rd == rs_i)) begin
            sel_o = FWD_MEM;
         end else if (is_writer(wb_i) && (wb_i.rd == rs_i)) begin
            sel_o = FWD_WB;
         end else if (is_writer(ret_i) && (ret_i.rd == rs_i)) begin
            sel_o = FWD_RET;
         end
      end
   end

endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: hazard and forwarding controller for the pipelined RV32I core.
//   clk_i, rst_ni          : core clock, async active-low reset
//   en_i                   : pipeline advance (0 = memory wait, all state holds)
//   flush_i                : squash the instruction in ID
//   id_*                   : register metadata of the instruction in ID
//   fwd_a_sel_o/fwd_b_sel_o: EX operand mux selects (from shadow state only)
//   stall_o                : load-use stall toward IF/ID, bubble into EX
//   stall_cnt_o/fwd_cnt_o  : saturating debug event counters
module forward_ctrl
   import forward_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             flush_i,
   input  logic             id_valid_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_rs1_use_i,
   input  logic             id_rs2_use_i,
   input  logic [4:0]       id_rd_i,
   input  logic             id_wren_i,
   input  logic             id_load_i,
   output logic [1:0]       fwd_a_sel_o,
   output logic [1:0]       fwd_b_sel_o,
   output logic             stall_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] fwd_cnt_o
);

   stage_ctrl_t ex_q, mem_q, wb_q, ret_q;
   stage_ctrl_t id_stage, ex_d;
   logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;
   logic ex_load_wr, fwd_any;

   always_comb begin
      id_stage         = STAGE_BUBBLE;
      id_stage.valid   = id_valid_i;
      id_stage.rd      = id_rd_i;
      id_stage.wren    = id_wren_i;
      id_stage.load    = id_load_i;
      id_stage.rs1     = id_rs1_i;
      id_stage.rs2     = id_rs2_i;
      id_stage.rs1_use = id_rs1_use_i;
      id_stage.rs2_use = id_rs2_use_i;
   end

   // A load in EX has no data until MEM completes, so a dependent ID must wait one cycle.
   assign ex_load_wr = is_writer(ex_q) & ex_q.load;
   assign stall_o    = id_valid_i & ~flush_i & ex_load_wr &
                       ((id_rs1_use_i & (id_rs1_i == ex_q.rd)) |
                        (id_rs2_use_i & (id_rs2_i == ex_q.rd)));

   always_comb begin
      ex_d = id_stage;
      if (flush_i || stall_o || !id_valid_i) begin
         ex_d = STAGE_BUBBLE;
      end
   end

   fwd_sel_cmp u_cmp_a (
      .rs_i     (ex_q.rs1),
      .rs_use_i (ex_q.valid & ex_q.rs1_use),
      .mem_i    (mem_q),
      .wb_i     (wb_q),
      .ret_i    (ret_q),
      .sel_o    (fwd_a_sel_o)
   );

   fwd_sel_cmp u_cmp_b (
      .rs_i     (ex_q.rs2),
      .rs_use_i (ex_q.valid & ex_q.rs2_use),
      .mem_i    (mem_q),
      .wb_i     (wb_q),
      .ret_i    (ret_q),
      .sel_o    (fwd_b_sel_o)
   );

   assign fwd_any = (fwd_a_sel_o != FWD_RF) | (fwd_b_sel_o != FWD_RF);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ex_q        <= STAGE_BUBBLE;
         mem_q       <= STAGE_BUBBLE;
         wb_q        <= STAGE_BUBBLE;
         ret_q       <= STAGE_BUBBLE;
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else if (en_i) begin
         ret_q <= wb_q;
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= ex_d;
         if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (fwd_any && (fwd_cnt_q != '1)) begin
            fwd_cnt_q <= fwd_cnt_q + 1'b1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign fwd_cnt_o   = fwd_cnt_q;

endmodule

// File: tb/tb_forward_ctrl.sv
module tb_forward_ctrl;

   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   typedef struct packed {
      bit       v;
      bit [4:0] rd;
      bit       wr;
      bit       ld;
      bit [4:0] rs1;
      bit [4:0] rs2;
      bit       u1;
      bit       u2;
   } instr_t;

   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
      logic       st;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          en_i = 1'b0;
   logic          flush_i = 1'b0;
   logic          id_valid_i = 1'b0;
   logic [4:0]    id_rs1_i = '0;
   logic [4:0]    id_rs2_i = '0;
   logic          id_rs1_use_i = 1'b0;
   logic          id_rs2_use_i = 1'b0;
   logic [4:0]    id_rd_i = '0;
   logic          id_wren_i = 1'b0;
   logic          id_load_i = 1'b0;
   logic [1:0]    fwd_a_sel_o;
   logic [1:0]    fwd_b_sel_o;
   logic          stall_o;
   logic [CW-1:0] stall_cnt_o;
   logic [CW-1:0] fwd_cnt_o;

   always #5 clk_i = ~clk_i;

   forward_ctrl #(.CNT_W(CW)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .en_i         (en_i),
      .flush_i      (flush_i),
      .id_valid_i   (id_valid_i),
      .id_rs1_i     (id_rs1_i),
      .id_rs2_i     (id_rs2_i),
      .id_rs1_use_i (id_rs1_use_i),
      .id_rs2_use_i (id_rs2_use_i),
      .id_rd_i      (id_rd_i),
      .id_wren_i    (id_wren_i),
      .id_load_i    (id_load_i),
      .fwd_a_sel_o  (fwd_a_sel_o),
      .fwd_b_sel_o  (fwd_b_sel_o),
      .stall_o      (stall_o),
      .stall_cnt_o  (stall_cnt_o),
      .fwd_cnt_o    (fwd_cnt_o)
   );

   // Reference model: pipe[d] is the instruction d slots older than the one in EX.
   instr_t pipe [4];
   int     m_sc, m_fc;
   exp_t   exp_q [$];
   int     n_chk = 0;
   int     n_fail = 0;
   instr_t cur_id;
   bit     cur_fl, cur_en, cur_stall;
   logic [1:0] cur_a, cur_b;

   task automatic check(string name, logic [31:0] act, logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Nearest older writer of rs wins; its distance is the select code.
   function automatic logic [1:0] m_sel(bit [4:0] rs, bit u);
      if (!pipe[0].v || !u || rs == 5'd0) return 2'd0;
      for (int d = 1; d < 4; d++) begin
         if (pipe[d].v && pipe[d].wr && pipe[d].rd == rs) return 2'(d);
      end
      return 2'd0;
   endfunction

   function automatic instr_t mk(bit [4:0] rd, bit wr, bit ld, bit [4:0] rs1, bit u1,
                                 bit [4:0] rs2, bit u2);
      instr_t i;
      i.v = 1'b1; i.rd = rd; i.wr = wr; i.ld = ld;
      i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
      return i;
   endfunction

   function automatic instr_t idle();
      instr_t i;
      i = '0;
      return i;
   endfunction

   task automatic drive(instr_t i, bit fl, bit en);
      exp_t e;
      id_valid_i = i.v;  id_rd_i = i.rd;  id_wren_i = i.wr;  id_load_i = i.ld;
      id_rs1_i = i.rs1;  id_rs2_i = i.rs2;  id_rs1_use_i = i.u1;  id_rs2_use_i = i.u2;
      flush_i = fl;  en_i = en;
      cur_id = i;  cur_fl = fl;  cur_en = en;
      cur_a = m_sel(pipe[0].rs1, pipe[0].u1);
      cur_b = m_sel(pipe[0].rs2, pipe[0].u2);
      cur_stall = i.v && !fl && pipe[0].v && pipe[0].wr && pipe[0].ld && pipe[0].rd != 0 &&
                  ((i.u1 && i.rs1 == pipe[0].rd) || (i.u2 && i.rs2 == pipe[0].rd));
      e.a = cur_a;  e.b = cur_b;  e.st = cur_stall;
      e.sc = CW'(m_sc);  e.fc = CW'(m_fc);
      exp_q.push_back(e);
      #1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      if (cur_en) begin
         if (cur_stall && m_sc < SAT) m_sc++;
         if ((cur_a != 0 || cur_b != 0) && m_fc < SAT) m_fc++;
         pipe[3] = pipe[2];
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = (cur_fl || cur_stall || !cur_id.v) ? idle() : cur_id;
      end
      #1;
   endtask

   task automatic bubbles(int n);
      repeat (n) begin
         drive(idle(), 1'b0, 1'b1);
         tick();
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) pipe[k] = idle();
      m_sc = 0;
      m_fc = 0;
   endtask

   // Monitor: compares every cycle's DUT outputs against the queued model response.
   always @(negedge clk_i) begin
      exp_t e;
      if (rst_ni && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sb_sel_a", 32'(fwd_a_sel_o), 32'(e.a));
         check("sb_sel_b", 32'(fwd_b_sel_o), 32'(e.b));
         check("sb_stall", 32'(stall_o), 32'(e.st));
         check("sb_stall_cnt", 32'(stall_cnt_o), 32'(e.sc));
         check("sb_fwd_cnt", 32'(fwd_cnt_o), 32'(e.fc));
         check("mem_load_fwd",
               32'(((fwd_a_sel_o == 2'b01) || (fwd_b_sel_o == 2'b01)) && dut.mem_q.load), 32'd0);
      end
   end

   initial begin
      instr_t held, nxt;
      bit hold, fl, en;
      model_reset();
      cur_en = 1'b0;
      #12 rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // Reset state
      drive(idle(), 1'b0, 1'b1);
      check("rst_sel_a", 32'(fwd_a_sel_o), 32'd0);
      check("rst_sel_b", 32'(fwd_b_sel_o), 32'd0);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
      check("rst_fwd_cnt", 32'(fwd_cnt_o), 32'd0);
      tick();

      // add x5,x1,x2 ; sub x6,x5,x1
      drive(mk(5, 1, 0, 1, 1, 2, 1), 1'b0, 1'b1); tick();
      drive(mk(6, 1, 0, 5, 1, 1, 1), 1'b0, 1'b1); tick();
      drive(idle(), 1'b0, 1'b1);
      check("b2b_sel_a", 32'(fwd_a_sel_o), 32'd1);
      check("b2b_sel_b", 32'(fwd_b_sel_o), 32'd0);
      tick();
      drive(idle(), 1'b0, 1'b1);
      check("b2b_fwd_cnt", 32'(fwd_cnt_o), 32'd1);
      tick();
      bubbles(3);

      // Distance 2 on rs2
      drive(mk(7, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1); tick();
      drive(mk(10, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1); tick();
      drive(mk(15, 1, 0, 0, 0, 7, 1), 1'b0, 1'b1); tick();
      drive(idle(), 1'b0, 1'b1);
      check("dist2_sel_b", 32'(fwd_b_sel_o), 32'd2);
      tick();
      bubbles(3);

      // Distance 3 on rs2
      drive(mk(7, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1); tick();
      drive(mk(10, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1); tick();
      drive(mk(11, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1); tick();
      drive(mk(15, 1, 0, 0, 0, 7, 1), 1'b0, 1'b1); tick();
      drive(idle(), 1'b0, 1'b1);
      check("dist3_sel_b", 32'(fwd_b_sel_o), 32'd3);
      tick();
      bubbles(3);

      // lw x8 ; add x9,x8,x8
      drive(mk(8, 1, 1, 3, 1, 0, 0), 1'b0, 1'b1); tick();
      drive(mk(9, 1, 0, 8, 1, 8, 1), 1'b0, 1'b1);
      check("lu_stall_on", 32'(stall_o), 32'd1);
      tick();
      drive(mk(9, 1, 0, 8, 1, 8, 1), 1'b0, 1'b1);
      check("lu_stall_off", 32'(stall_o), 32'd0);
      tick();
      drive(idle(), 1'b0, 1'b1);
      check("lu_sel_a", 32'(fwd_a_sel_o), 32'd2);
      check("lu_sel_b", 32'(fwd_b_sel_o), 32'd2);
      check("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);
      tick();
      bubbles(3);

      // x0 never forwards; youngest writer of x4 wins
      drive(mk(0, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1); tick();
      drive(mk(12, 1, 0, 0, 1, 0, 1), 1'b0, 1'b1); tick();
      drive(idle(), 1'b0, 1'b1);
      check("x0_sel_a", 32'(fwd_a_sel_o), 32'd0);
      check("x0_sel_b", 32'(fwd_b_sel_o), 32'd0);
      tick();
      drive(mk(4, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1); tick();
      drive(mk(4, 1, 0, 0, 0, 0, 0), 1'b0, 1'b1); tick();
      drive(mk(13, 1, 0, 4, 1, 4, 1), 1'b0, 1'b1); tick();
      drive(idle(), 1'b0, 1'b1);
      check("prio_sel_a", 32'(fwd_a_sel_o), 32'd1);
      check("prio_sel_b", 32'(fwd_b_sel_o), 32'd1);
      tick();
      bubbles(3);

      // Flush beats stall: the squashed x14 writer must never reach EX
      drive(mk(13, 1, 1, 0, 0, 0, 0), 1'b0, 1'b1); tick();
      drive(mk(14, 1, 0, 13, 1, 0, 0), 1'b1, 1'b1);
      check("flush_stall", 32'(stall_o), 32'd0);
      tick();
      drive(mk(15, 1, 0, 14, 1, 0, 0), 1'b0, 1'b1); tick();
      drive(idle(), 1'b0, 1'b1);
      check("flush_bubble_sel_a", 32'(fwd_a_sel_o), 32'd0);
      check("flush_stall_cnt", 32'(stall_cnt_o), 32'd1);
      tick();
      bubbles(3);

      // Stall held through en_i = 0, then async reset mid-cycle
      drive(mk(14, 1, 1, 0, 0, 0, 0), 1'b0, 1'b1); tick();
      repeat (3) begin
         drive(mk(15, 1, 0, 0, 0, 14, 1), 1'b0, 1'b0);
         check("hold_stall", 32'(stall_o), 32'd1);
         check("hold_stall_cnt", 32'(stall_cnt_o), 32'd1);
         tick();
      end
      drive(mk(15, 1, 0, 0, 0, 14, 1), 1'b0, 1'b0);
      rst_ni = 1'b0;
      exp_q.delete();
      model_reset();
      #1;
      check("arst_stall", 32'(stall_o), 32'd0);
      check("arst_sel_a", 32'(fwd_a_sel_o), 32'd0);
      check("arst_sel_b", 32'(fwd_b_sel_o), 32'd0);
      check("arst_stall_cnt", 32'(stall_cnt_o), 32'd0);
      check("arst_fwd_cnt", 32'(fwd_cnt_o), 32'd0);
      #1 rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // Randomized traffic; ID holds while stalled or not advancing
      hold = 1'b0;
      held = idle();
      for (int n = 0; n < 1500; n++) begin
         if (hold) begin
            nxt = held;
         end else begin
            nxt.v   = ($urandom_range(0, 6) != 0);
            nxt.rd  = 5'($urandom_range(0, 7));
            nxt.wr  = ($urandom_range(0, 4) != 0);
            nxt.ld  = ($urandom_range(0, 2) == 0);
            nxt.rs1 = 5'($urandom_range(0, 7));
            nxt.rs2 = 5'($urandom_range(0, 7));
            nxt.u1  = ($urandom_range(0, 3) != 0);
            nxt.u2  = ($urandom_range(0, 1) != 0);
         end
         fl = ($urandom_range(0, 9) == 0);
         en = ($urandom_range(0, 4) != 0);
         drive(nxt, fl, en);
         hold = !fl && (cur_stall || !en);
         held = nxt;
         tick();
      end

      drive(idle(), 1'b0, 1'b1);
      @(negedge clk_i); #1;
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/forward_ctrl.md
# forward_ctrl

Pipeline hazard and forwarding controller for the milestone-3 pipelined RV32I core. It sits on the control side of the EX-stage operand `mux4input` instances and generates their 2-bit `select_i` codes. It tracks destination-register metadata for the EX, MEM, WB and retired stages in its own shadow pipeline. It raises a load-use stall toward IF/ID, and it keeps saturating stall and forward event counters for debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of the event counters.

Ports (clock and reset first):
- `clk_i` input 1: core clock.
- `rst_ni` input 1: asynchronous, active-low reset.
- `en_i` input 1: global pipeline advance. 0 = memory wait, and every shadow register holds.
- `flush_i` input 1: taken branch or jump. The instruction in ID is squashed.
- `id_valid_i` input 1: ID holds a real instruction.
- `id_rs1_i` input 5: ID source register 1 address.
- `id_rs2_i` input 5: ID source register 2 address.
- `id_rs1_use_i` input 1: ID instruction reads rs1.
- `id_rs2_use_i` input 1: ID instruction reads rs2.
- `id_rd_i` input 5: ID destination register address.
- `id_wren_i` input 1: ID instruction writes rd.
- `id_load_i` input 1: ID instruction is a load.
- `fwd_a_sel_o` output 2: select for the EX operand-A mux.
- `fwd_b_sel_o` output 2: select for the EX operand-B mux.
- `stall_o` output 1: hold PC and IF/ID, and inject a bubble into EX.
- `stall_cnt_o` output CNT_W: saturating count of stall cycles.
- `fwd_cnt_o` output CNT_W: saturating count of cycles where any forward select is nonzero.

## Operation
- The shadow stages EX, MEM, WB and RET each hold `{valid, rd, wren, load, rs1, rs2, rs1_use, rs2_use}`.
- A stage is a writer when `valid & wren & rd != 0`.
- Advance rule, applied on the rising clock edge when `en_i = 1`:
  - RET <= WB, WB <= MEM, MEM <= EX.
  - EX <= a bubble (valid = 0) if `flush_i | stall_o | !id_valid_i`.
  - Otherwise EX <= the ID fields.
- When `en_i = 0`, all stages hold. Counters do not increment.
- Select encoding, evaluated independently for each operand using EX.rs1/rs1_use for A and EX.rs2/rs2_use for B. Highest priority first:
  - `2'b01` if MEM is a writer with matching rd: the ALU result from EX/MEM.
  - `2'b10` if WB is a writer with matching rd: the writeback value from MEM/WB.
  - `2'b11` if RET is a writer with matching rd: the retired-value register, which covers the regfile having no write-through.
  - `2'b00` otherwise, including when EX is invalid, the operand is unused, or the address is x0: the register-file read.
- A MEM match with MEM.load = 1 cannot occur, because the load-use stall prevents it. The bench asserts this.
- `stall_o` = `id_valid_i & !flush_i` & EX is a writer & EX.load & ((rs1_use & rs1 == EX.rd) | (rs2_use & rs2 == EX.rd)).
- A stall lasts exactly one advancing cycle. After the bubble enters EX, the load sits in MEM and the hazard is resolved by select `10` one cycle later.
- Priority for simultaneous events: `flush_i` beats stall. When `en_i = 0`, `stall_o` remains combinationally valid, but no state changes.
- Counters: `stall_cnt_o` += 1 on each advancing cycle with `stall_o = 1`. `fwd_cnt_o` += 1 on each advancing cycle with either select nonzero. Both saturate at all-ones and never wrap.

## Timing
- Reset (async assert, sync-safe release): all stage valid bits = 0, so both selects = `2'b00`, `stall_o` = 0, and both counters = 0.
- Forward selects are combinational from shadow registers only, with no path from the ID inputs, so they are valid early in each cycle.
- `stall_o` is combinational from the ID inputs and the EX register. It is zero-latency and is consumed in the same cycle.
- An ID→EX transfer shows up in the selects 1 cycle later. A producer-to-consumer distance of 1, 2 or 3 instructions yields select 01, 10 or 11 respectively.
- Reset asserted mid-stall: `stall_o` drops immediately, and all shadow state clears.

## Structure
- Package `forward_ctrl_pkg` contains:
  - typedef `stage_ctrl_t` (the shadow stage record).
  - localparams `FWD_RF = 2'b00`, `FWD_MEM = 2'b01`, `FWD_WB = 2'b10`, `FWD_RET = 2'b11`. These must equal `` `DATA_00 ``..`` `DATA_11 `` as consumed by `mux4input`.
- Sub-module `fwd_sel_cmp`: a combinational priority comparator with inputs (rs, use, MEM, WB, RET) and a 2-bit select output. It is instantiated twice, once for operand A and once for operand B.
- Top level: the four stage registers, the stall logic, and the counters.

## Test plan
- Back-to-back dependency: `add x5,..` then `sub x6,x5,x1` → in the sub's EX cycle, `fwd_a_sel_o = 01`, `fwd_b_sel_o = 00`, and `fwd_cnt_o` is incremented by 1.
- Distance 2 and 3: writer of x7, then 1 or 2 unrelated instructions, then a reader of x7 on rs2 → `fwd_b_sel_o` = 10 at distance 2, and 11 at distance 3.
- Load-use: `lw x8` then `add x9,x8,x8` → `stall_o = 1` for exactly 1 cycle, then a bubble in EX, then the add in EX with both selects = 10. `stall_cnt_o` = 1.
- x0 and priority: writes to x0 never forward (select 00). Writers of x4 in both MEM and WB give select 01, because the youngest wins.
- Flush during stall: a load in EX with a dependent instruction in ID and `flush_i = 1` → `stall_o = 0`, EX receives a bubble, and `stall_cnt_o` is unchanged.
- `en_i = 0` for 3 cycles during a stall, then an async reset pulse → all state holds while `en_i` is low. Reset immediately forces all outputs to 0.
